// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: serialises IF fetches and MEM accesses
// onto one downstream port, with a one-cycle turnaround between grants.
module mem_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_memaddr,
    input  logic [1:0]  if_mem_byte_enable,
    input  logic        if_memread,
    output logic        if_mem_resp,
    output logic [15:0] if_mem_rdata,
    input  logic [15:0] mem_memaddr,
    input  logic [1:0]  mem_mem_byte_enable,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic [15:0] mem_mem_wdata,
    output logic        mem_mem_resp,
    output logic [15:0] mem_mem_rdata,
    output logic [15:0] pmem_address,
    output logic [1:0]  pmem_byte_enable,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_wdata,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_IF  = 2'd1,
        SERVE_MEM = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_grant;
    logic   if_req;
    logic   mem_req;

    assign if_req  = if_memread;
    assign mem_req = mem_memread | mem_memwrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                if (next_state == SERVE_IF)
                    last_grant <= 1'b0;
                else if (next_state == SERVE_MEM)
                    last_grant <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (if_req && mem_req) begin
                    if (FAIR && last_grant)
                        next_state = SERVE_IF;
                    else
                        next_state = SERVE_MEM;
                end else if (if_req) begin
                    next_state = SERVE_IF;
                end else if (mem_req) begin
                    next_state = SERVE_MEM;
                end
            end
            // Completion and abort both release the grant into turnaround
            SERVE_IF: begin
                if (pmem_resp || !if_req)
                    next_state = IDLE;
            end
            SERVE_MEM: begin
                if (pmem_resp || !mem_req)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pmem_address     = 16'h0000;
        pmem_byte_enable = 2'b00;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_wdata       = 16'h0000;
        unique case (state)
            SERVE_IF: begin
                pmem_address     = if_memaddr;
                pmem_byte_enable = if_mem_byte_enable;
                pmem_read        = if_memread;
            end
            SERVE_MEM: begin
                pmem_address     = mem_memaddr;
                pmem_byte_enable = mem_mem_byte_enable;
                pmem_write       = mem_memwrite;
                pmem_read        = mem_memread & ~mem_memwrite;
                pmem_wdata       = mem_mem_wdata;
            end
            default: ;
        endcase
    end

    // A completion coinciding with reset is dropped
    assign if_mem_resp   = pmem_resp & ~reset & (state == SERVE_IF);
    assign mem_mem_resp  = pmem_resp & ~reset & (state == SERVE_MEM);
    assign if_mem_rdata  = pmem_rdata;
    assign mem_mem_rdata = pmem_rdata;

endmodule
